// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer feeding the Sobel 3x3 window stage with vertical 3-pixel columns.
// Optional status ports (err_o, frame_cnt_o) enabled by SOBEL_FRAME_CTRL_STATUS_EN.
module sobel_frame_ctrl #(
    parameter int ROWS      = 512,
    parameter int COLS      = 512,
    parameter int CNT_W     = 10,
    parameter int TAIL_COLS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] pix_i,
    input  logic       pix_valid_i,
    output logic       pix_ready_o,
    output logic [7:0] d0_o,
    output logic [7:0] d1_o,
    output logic [7:0] d2_o,
    output logic       col_valid_o,
    output logic       busy_o,
`ifdef SOBEL_FRAME_CTRL_STATUS_EN
    output logic        err_o,
    output logic [15:0] frame_cnt_o,
`endif
    output logic       frame_done_o
);
    localparam int AW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(COLS - 1);
    localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(TAIL_COLS - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_FLUSH, S_TAIL, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
    logic [7:0]       d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
    logic             cv_q, cv_d, busy_q, busy_d, done_q, done_d;
    logic             lba_we, lbb_we, accept;
    logic [AW-1:0]    idx;
    logic [7:0]       lba_rd, lbb_rd;

    // Line buffers hold no reset: every entry is written before it is read,
    // except lbB during row 1, which is masked to zero below.
    logic [7:0] lba_q [COLS];
    logic [7:0] lbb_q [COLS];

    assign idx         = col_q[AW-1:0];
    assign lba_rd      = lba_q[idx];
    assign lbb_rd      = lbb_q[idx];
    assign pix_ready_o = (state_q == S_PRIME) || (state_q == S_RUN);
    assign accept      = pix_valid_i & pix_ready_o;

    always_ff @(posedge clk) begin
        if (lba_we) lba_q[idx] <= pix_i;
        if (lbb_we) lbb_q[idx] <= lba_rd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            cv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            cv_q    <= cv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        cv_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        lba_we  = 1'b0;
        lbb_we  = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d = S_PRIME;
                col_d   = '0;
                row_d   = '0;
                busy_d  = 1'b1;
            end
            S_PRIME: if (accept) begin
                lba_we = 1'b1;
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    row_d   = CNT_W'(1);
                    state_d = S_RUN;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_RUN: if (accept) begin
                d0_d   = pix_i;
                d1_d   = lba_rd;
                d2_d   = (row_q == CNT_W'(1)) ? 8'd0 : lbb_rd;
                cv_d   = 1'b1;
                lba_we = 1'b1;
                lbb_we = 1'b1;
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    if (row_q == LAST_ROW) state_d = S_FLUSH;
                    else                   row_d   = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_FLUSH: begin
                d0_d = 8'd0;
                d1_d = lba_rd;
                d2_d = lbb_rd;
                cv_d = 1'b1;
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    state_d = S_TAIL;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_TAIL: begin
                d0_d = 8'd0;
                d1_d = 8'd0;
                d2_d = 8'd0;
                cv_d = 1'b1;
                if (col_q == LAST_TAIL) begin
                    col_d   = '0;
                    state_d = S_DONE;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign d0_o         = d0_q;
    assign d1_o         = d1_q;
    assign d2_o         = d2_q;
    assign col_valid_o  = cv_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

`ifdef SOBEL_FRAME_CTRL_STATUS_EN
    logic        err_q, err_d;
    logic [15:0] fcnt_q, fcnt_d;

    always_comb begin
        err_d  = err_q
               | (start_i & (state_q != S_IDLE))
               | (pix_valid_i & ((state_q == S_IDLE) || (state_q == S_FLUSH) || (state_q == S_TAIL)));
        fcnt_d = done_d ? fcnt_q + 16'd1 : fcnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q  <= 1'b0;
            fcnt_q <= '0;
        end else begin
            err_q  <= err_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign err_o       = err_q;
    assign frame_cnt_o = fcnt_q;
`endif
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl: directed frame scenarios with random pixels,
// columns compared against a frame-level reference built from the pixel image.
module tb_sobel_frame_ctrl;
    localparam int R = 3;
    localparam int C = 4;
    localparam int T = 1;
    localparam int NCOL = R * C - C + C + T;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] pix_i = 8'd0;
    logic       pix_valid_i = 1'b0;
    logic       pix_ready_o, col_valid_o, busy_o, frame_done_o;
    logic [7:0] d0_o, d1_o, d2_o;
`ifdef SOBEL_FRAME_CTRL_STATUS_EN
    logic        err_o;
    logic [15:0] frame_cnt_o;
`endif

    always #5 clk = ~clk;

    sobel_frame_ctrl #(.ROWS(R), .COLS(C), .CNT_W(10), .TAIL_COLS(T)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .pix_i(pix_i), .pix_valid_i(pix_valid_i),
        .pix_ready_o(pix_ready_o), .d0_o(d0_o), .d1_o(d1_o), .d2_o(d2_o),
        .col_valid_o(col_valid_o), .busy_o(busy_o),
`ifdef SOBEL_FRAME_CTRL_STATUS_EN
        .err_o(err_o), .frame_cnt_o(frame_cnt_o),
`endif
        .frame_done_o(frame_done_o)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          strobes;
    int          frames = 0;
    bit          got_done;
    logic [23:0] exp_q[$];
    logic [7:0]  img[R*C];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one clock and sample #1 later; every column strobe is checked in order.
    task automatic tick();
        logic [23:0] e;
        @(posedge clk);
        #1;
        if (frame_done_o) got_done = 1'b1;
        if (col_valid_o) begin
            strobes++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hxxxxxx;
            chk("column", {8'd0, d0_o, d1_o, d2_o}, {8'd0, e});
        end
    endtask

    // Reference: each row r>=1 yields {row r, row r-1, row r-2 or 0}, then the flush
    // columns {0, last row, row above}, then TAIL zero columns.
    task automatic build(input bit seq);
        exp_q.delete();
        for (int i = 0; i < R * C; i++) img[i] = seq ? 8'(i + 1) : 8'($urandom_range(0, 255));
        for (int r = 1; r < R; r++)
            for (int c = 0; c < C; c++)
                exp_q.push_back({img[r*C+c], img[(r-1)*C+c], (r >= 2) ? img[(r-2)*C+c] : 8'd0});
        for (int c = 0; c < C; c++)
            exp_q.push_back({8'd0, img[(R-1)*C+c], img[(R-2)*C+c]});
        for (int t = 0; t < T; t++) exp_q.push_back(24'd0);
    endtask

    task automatic run_frame(input bit seq, input bit gap, input bit inj, input bit b2b, input bit junk);
        int idx, cyc;
        bit ph, acc;
        build(seq);
        strobes  = 0;
        got_done = 1'b0;
        start_i  = 1'b1;
        tick();
        start_i = 1'b0;
        chk("busy_after_start", {31'd0, busy_o}, 32'd1);
        idx = 0; cyc = 0; ph = 1'b1;
        while (idx < R * C && cyc < 500) begin
            pix_valid_i = gap ? ph : 1'b1;
            ph          = ~ph;
            pix_i       = img[idx];
            start_i     = inj && (idx == 6);
            acc         = pix_valid_i & pix_ready_o;
            tick();
            start_i = 1'b0;
            chk("strobe_latency", {31'd0, col_valid_o}, {31'd0, acc && (idx >= C)});
            if (acc) idx++;
            cyc++;
        end
        chk("pixels_accepted", idx, R * C);
        pix_valid_i = junk;
        pix_i       = 8'hA5;
        cyc = 0;
        while (!got_done && cyc < 100) begin
            chk("ready_low_drain", {31'd0, pix_ready_o}, 32'd0);
            tick();
            start_i = inj && col_valid_o && (exp_q.size() == 0);
            cyc++;
        end
        start_i     = 1'b0;
        pix_valid_i = 1'b0;
        chk("frame_done", {31'd0, got_done}, 32'd1);
        chk("busy_at_done", {31'd0, busy_o}, 32'd0);
        chk("strobe_count", strobes, NCOL);
        chk("exp_drained", exp_q.size(), 0);
        frames++;
        if (!b2b) begin
            tick();
            chk("done_one_cycle", {31'd0, frame_done_o}, 32'd0);
            chk("idle_after_done", {30'd0, busy_o, col_valid_o}, 32'd0);
        end
`ifdef SOBEL_FRAME_CTRL_STATUS_EN
        chk("frame_cnt", {16'd0, frame_cnt_o}, frames);
`endif
    endtask

    initial begin
        int idx;
        exp_q.delete();
        strobes = 0; got_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {26'd0, busy_o, col_valid_o, pix_ready_o, frame_done_o, 2'b00}, 32'd0);
        chk("reset_data", {8'd0, d0_o, d1_o, d2_o}, 32'd0);
        rst = 1'b1;
        tick();
        chk("idle_ready", {31'd0, pix_ready_o}, 32'd0);

        run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SOBEL_FRAME_CTRL_STATUS_EN
        chk("err_clean", {31'd0, err_o}, 32'd0);
`endif
        run_frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef SOBEL_FRAME_CTRL_STATUS_EN
        chk("err_sticky", {31'd0, err_o}, 32'd1);
`endif
        run_frame(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of row 1.
        build(1'b0);
        strobes = 0; got_done = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        idx = 0;
        for (int k = 0; k < 50 && idx < C + 2; k++) begin
            pix_valid_i = 1'b1;
            pix_i       = img[idx];
            if (pix_ready_o) idx++;
            tick();
        end
        chk("mid_run_strobes", strobes, 2);
        pix_valid_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_reset", {28'd0, busy_o, col_valid_o, pix_ready_o, frame_done_o}, 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b1;
        repeat (4) tick();
        chk("no_done_after_reset", {31'd0, got_done}, 32'd0);
        chk("idle_after_reset", {30'd0, busy_o, pix_ready_o}, 32'd0);
        frames = 0;
`ifdef SOBEL_FRAME_CTRL_STATUS_EN
        chk("err_reset", {31'd0, err_o}, 32'd0);
`endif
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) run_frame(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
